// File: rtl/bank_write_arbiter.sv
// Buffers writeback requests per port and grants one write per X/Y bank per cycle; bank_we lands 2 cycles after accept.
// wb_ready drops while a port FIFO is full; BANK_WRITE_ARB_RR_EN selects per-bank round-robin, else lowest port wins.
module bank_write_arbiter #(
  parameter int PORT_NUM     = 3,
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 6,
  parameter int ADDR_X_SIZE  = 1,
  parameter int ADDR_X_WIDTH = 1,
  parameter int ADDR_Y_SIZE  = 16,
  parameter int ADDR_Y_WIDTH = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUM-1:0]            wb_valid,
  output logic [PORT_NUM-1:0]            wb_ready,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] wb_addr,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] wb_data,
  output logic [3:0]                     bank_we,
  output logic [4*ADDR_Y_WIDTH-1:0]      bank_waddr,
  output logic [4*DATA_WIDTH-1:0]        bank_wdata,
  output logic                           idle
);

  localparam int EW  = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PIW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [PORT_NUM-1:0]     head_vld;
  logic [PORT_NUM-1:0]     pop;
  logic [EW-1:0]           head_dat   [PORT_NUM];
  logic [1:0]              head_bank  [PORT_NUM];
  logic [ADDR_Y_WIDTH-1:0] head_laddr [PORT_NUM];
  logic [3:0]              gnt_vld;
  logic [PIW-1:0]          gnt_idx    [4];

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    logic [EW-1:0]                mem [FIFO_DEPTH];
    logic [PW-1:0]                rd_ptr;
    logic [PW-1:0]                wr_ptr;
    logic [CW-1:0]                count;
    logic                         push;
    logic [ADDR_WIDTH-1:0]        haddr;
    logic [ADDR_X_WIDTH-1:0]      addr_x;
    logic [ADDR_WIDTH-ADDR_X_WIDTH-1:0] addr_y;

    // Ready comes from the registered count only, so a full FIFO never pushes while it pops.
    assign wb_ready[p]  = !rst && (count < CW'(FIFO_DEPTH));
    assign push         = wb_valid[p] && wb_ready[p];
    assign head_vld[p]  = (count != '0);
    assign head_dat[p]  = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        if (pop[p])
          rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop[p]);
      end
    end

    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= {wb_addr[p*ADDR_WIDTH +: ADDR_WIDTH], wb_data[p*DATA_WIDTH +: DATA_WIDTH]};
    end

    assign haddr          = head_dat[p][EW-1 -: ADDR_WIDTH];
    assign addr_x         = haddr[ADDR_X_WIDTH-1:0];
    assign addr_y         = haddr[ADDR_WIDTH-1:ADDR_X_WIDTH];
    assign head_bank[p]   = {32'(addr_x) >= ADDR_X_SIZE, 32'(addr_y) >= ADDR_Y_SIZE};
    assign head_laddr[p]  = haddr[ADDR_X_WIDTH +: ADDR_Y_WIDTH];
  end

`ifdef BANK_WRITE_ARB_RR_EN
  logic [PIW-1:0] rr_ptr [4];
  logic [PIW-1:0] cand;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (rst)
        rr_ptr[b] <= '0;
      else if (gnt_vld[b])
        rr_ptr[b] <= (gnt_idx[b] == PIW'(PORT_NUM - 1)) ? '0 : gnt_idx[b] + PIW'(1);
    end
  end
`endif

  always_comb begin
    gnt_vld = '0;
    pop     = '0;
`ifdef BANK_WRITE_ARB_RR_EN
    cand    = '0;
`endif
    for (int b = 0; b < 4; b++) begin
      gnt_idx[b] = '0;
`ifdef BANK_WRITE_ARB_RR_EN
      for (int i = 0; i < PORT_NUM; i++) begin
        cand = PIW'((int'(rr_ptr[b]) + i) % PORT_NUM);
        if (!gnt_vld[b] && head_vld[cand] && head_bank[cand] == 2'(b)) begin
          gnt_vld[b] = 1'b1;
          gnt_idx[b] = cand;
        end
      end
`else
      // Scan downwards so the lowest requesting port is the last (winning) assignment.
      for (int p = PORT_NUM - 1; p >= 0; p--) begin
        if (head_vld[p] && head_bank[p] == 2'(b)) begin
          gnt_vld[b] = 1'b1;
          gnt_idx[b] = PIW'(p);
        end
      end
`endif
      if (gnt_vld[b])
        pop[gnt_idx[b]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_we    <= '0;
      bank_waddr <= '0;
      bank_wdata <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        bank_we[b] <= gnt_vld[b];
        if (gnt_vld[b]) begin
          bank_waddr[b*ADDR_Y_WIDTH +: ADDR_Y_WIDTH] <= head_laddr[gnt_idx[b]];
          bank_wdata[b*DATA_WIDTH +: DATA_WIDTH]     <= head_dat[gnt_idx[b]][DATA_WIDTH-1:0];
        end
      end
    end
  end

  assign idle = (head_vld == '0) && (bank_we == '0);

endmodule

// File: tb/tb_bank_write_arbiter.sv
// Randomized and directed checks of bank_write_arbiter against a queue-based reference model.
module tb_bank_write_arbiter;
  localparam int P = 3, DW = 128, AW = 6, XS = 1, XW = 1, YS = 16, YW = 4, DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    wb_valid;
  logic [P-1:0]    wb_ready;
  logic [P*AW-1:0] wb_addr;
  logic [P*DW-1:0] wb_data;
  logic [3:0]      bank_we;
  logic [4*YW-1:0] bank_waddr;
  logic [4*DW-1:0] bank_wdata;
  logic            idle;

  always #5 clk = ~clk;

  bank_write_arbiter #(
    .PORT_NUM(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_X_SIZE(XS), .ADDR_X_WIDTH(XW),
    .ADDR_Y_SIZE(YS), .ADDR_Y_WIDTH(YW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .bank_we(bank_we), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .idle(idle)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-port queues of {addr, data} and the expected registered bank outputs.
  logic [AW+DW-1:0] mq [P][$];
  logic [3:0]       m_we;
  logic [YW-1:0]    m_waddr [4];
  logic [DW-1:0]    m_wdata [4];
`ifdef BANK_WRITE_ARB_RR_EN
  int               m_ptr [4];
`endif

  function automatic int bank_of(input logic [AW-1:0] a);
    int x, y;
    x = int'(a) % (1 << XW);
    y = int'(a) >> XW;
    return ((x >= XS) ? 2 : 0) + ((y >= YS) ? 1 : 0);
  endfunction

  function automatic logic [YW-1:0] local_of(input logic [AW-1:0] a);
    return YW'((int'(a) >> XW) % (1 << YW));
  endfunction

  function automatic logic [P-1:0] m_ready();
    logic [P-1:0] r;
    for (int p = 0; p < P; p++) r[p] = !rst && (mq[p].size() < DEPTH);
    return r;
  endfunction

  function automatic logic m_idle();
    logic e;
    e = (m_we == 4'b0);
    for (int p = 0; p < P; p++) if (mq[p].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic model_edge();
    logic [P-1:0]     acc;
    logic [P-1:0]     popm;
    logic [AW+DW-1:0] h;
    int               win;
    int               p;
    if (rst) begin
      for (int q = 0; q < P; q++) mq[q].delete();
      for (int b = 0; b < 4; b++) begin
        m_waddr[b] = '0;
        m_wdata[b] = '0;
`ifdef BANK_WRITE_ARB_RR_EN
        m_ptr[b] = 0;
`endif
      end
      m_we = '0;
      return;
    end
    acc  = m_ready() & wb_valid;
    popm = '0;
    for (int b = 0; b < 4; b++) begin
      win = -1;
      for (int i = 0; i < P; i++) begin
`ifdef BANK_WRITE_ARB_RR_EN
        p = (m_ptr[b] + i) % P;
`else
        p = i;
`endif
        if (win < 0 && mq[p].size() > 0) begin
          h = mq[p][0];
          if (bank_of(h[AW+DW-1 -: AW]) == b) win = p;
        end
      end
      m_we[b] = (win >= 0);
      if (win >= 0) begin
        h = mq[win][0];
        m_waddr[b] = local_of(h[AW+DW-1 -: AW]);
        m_wdata[b] = h[DW-1:0];
        popm[win]  = 1'b1;
`ifdef BANK_WRITE_ARB_RR_EN
        m_ptr[b] = (win + 1) % P;
`endif
      end
    end
    for (int q = 0; q < P; q++) begin
      if (popm[q]) void'(mq[q].pop_front());
      if (acc[q]) mq[q].push_back({wb_addr[q*AW +: AW], wb_data[q*DW +: DW]});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid[p]        = v;
    wb_addr[p*AW +: AW] = a;
    wb_data[p*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = '0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    cycle();
    cycle();
    n_tests++; if (wb_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready_in_rst got %b exp 000", wb_ready); end
    n_tests++; if (bank_we !== 4'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0000", bank_we); end
    n_tests++; if (bank_waddr !== '0) begin n_fail++; $display("FAIL reset_waddr got %h exp 0", bank_waddr); end
    n_tests++; if (bank_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", bank_wdata); end
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", idle); end
    rst = 1'b0;
    cycle();
    n_tests++; if (wb_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready_after got %b exp 111", wb_ready); end
  endtask

  task automatic test_single_write();
    drive(0, 1'b1, 6'b000011, 128'hA5);
    cycle();
    drive(0, 1'b0, '0, '0);
    n_tests++; if (bank_we !== 4'b0000) begin n_fail++; $display("FAIL single_we_n1 got %b exp 0000", bank_we); end
    n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_idle_n1 got %b exp 0", idle); end
    cycle();
    n_tests++; if (bank_we !== 4'b0100) begin n_fail++; $display("FAIL single_we_n2 got %b exp 0100", bank_we); end
    n_tests++; if (bank_waddr[2*YW +: YW] !== 4'd1) begin n_fail++; $display("FAIL single_waddr got %0d exp 1", bank_waddr[2*YW +: YW]); end
    n_tests++; if (bank_wdata[2*DW +: DW] !== 128'hA5) begin n_fail++; $display("FAIL single_wdata got %h exp a5", bank_wdata[2*DW +: DW]); end
    cycle();
    n_tests++; if (bank_we !== 4'b0000 || idle !== 1'b1) begin n_fail++; $display("FAIL single_after we %b idle %b exp 0000/1", bank_we, idle); end
  endtask

  task automatic test_parallel_banks();
    drive(0, 1'b1, 6'b000000, 128'h10);
    drive(1, 1'b1, 6'b100000, 128'h20);
    drive(2, 1'b1, 6'b100001, 128'h30);
    cycle();
    for (int p = 0; p < P; p++) drive(p, 1'b0, '0, '0);
    cycle();
    n_tests++; if (bank_we !== 4'b1011) begin n_fail++; $display("FAIL parallel_we got %b exp 1011", bank_we); end
    n_tests++;
    if (bank_waddr[0 +: YW] !== 4'd0 || bank_waddr[YW +: YW] !== 4'd0 || bank_waddr[3*YW +: YW] !== 4'd0) begin
      n_fail++; $display("FAIL parallel_waddr got %h exp 0 on banks 0,1,3", bank_waddr);
    end
    n_tests++;
    if (bank_wdata[0 +: DW] !== 128'h10 || bank_wdata[DW +: DW] !== 128'h20 || bank_wdata[3*DW +: DW] !== 128'h30) begin
      n_fail++; $display("FAIL parallel_wdata got %h/%h/%h exp 10/20/30", bank_wdata[0 +: DW], bank_wdata[DW +: DW], bank_wdata[3*DW +: DW]);
    end
    cycle();
  endtask

  task automatic test_contention();
    int got[$];
    int exp_seq[6];
`ifdef BANK_WRITE_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < P; p++) drive(p, 1'b1, 6'b000000, DW'((c << 2) | p));
      cycle();
      n_tests++; if (bank_we !== m_we || wb_ready !== m_ready()) begin n_fail++; $display("FAIL contention_cyc%0d we %b rdy %b exp %b/%b", c, bank_we, wb_ready, m_we, m_ready()); end
      if (bank_we[0]) got.push_back(int'(bank_wdata[1:0]));
    end
    for (int p = 0; p < P; p++) drive(p, 1'b0, '0, '0);
    for (int c = 0; c < 10; c++) cycle();
    n_tests++; if (got.size() < 6) begin n_fail++; $display("FAIL contention_count got %0d exp >=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_tests++; if (got[i] !== exp_seq[i]) begin n_fail++; $display("FAIL contention_grant%0d got port %0d exp %0d", i, got[i], exp_seq[i]); end
    end
  endtask

  task automatic test_backpressure();
    int           got[$];
    int           k;
    bit           saw_stall, saw_resume;
    logic [P-1:0] r;
    k = 0; saw_stall = 0; saw_resume = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, c < 8, 6'b100000, '0);
      drive(1, k < 6, 6'b100010, {8'h11, 120'(k)});
      drive(2, 1'b0, '0, '0);
      r = m_ready();
      cycle();
      if (k < 6 && r[1]) k++;
      n_tests++; if (wb_ready !== m_ready()) begin n_fail++; $display("FAIL bp_ready_cyc%0d got %b exp %b", c, wb_ready, m_ready()); end
      n_tests++; if (bank_we !== m_we) begin n_fail++; $display("FAIL bp_we_cyc%0d got %b exp %b", c, bank_we, m_we); end
      if (!wb_ready[1]) saw_stall = 1;
      else if (saw_stall && k < 6) saw_resume = 1;
      if (bank_we[1] && bank_wdata[2*DW-1 -: 8] == 8'h11) got.push_back(int'(bank_wdata[DW +: 8]));
    end
    n_tests++; if (!saw_stall || !saw_resume) begin n_fail++; $display("FAIL bp_stall_resume got %b%b exp 11", saw_stall, saw_resume); end
    n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d exp 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_tests++; if (got[i] != i) begin n_fail++; $display("FAIL bp_order%0d got %0d exp %0d", i, got[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      for (int p = 0; p < P; p++) drive(p, 1'b1, AW'(p * 2), DW'(c + 100));
      cycle();
    end
    for (int p = 0; p < P; p++) drive(p, 1'b0, '0, '0);
    rst = 1'b1;
    cycle();
    n_tests++; if (bank_we !== 4'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_out we %b idle %b exp 0000/1", bank_we, idle); end
    n_tests++; if (wb_ready !== 3'b000) begin n_fail++; $display("FAIL rstmid_ready_in_rst got %b exp 000", wb_ready); end
    rst = 1'b0;
    cycle();
    n_tests++; if (wb_ready !== 3'b111) begin n_fail++; $display("FAIL rstmid_ready_after got %b exp 111", wb_ready); end
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_tests++; if (bank_we !== 4'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rstmid_stale_cyc%0d we %b idle %b exp 0000/1", c, bank_we, idle); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < P; p++)
        drive(p, $urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)),
              {$urandom(), $urandom(), $urandom(), $urandom()});
      cycle();
      n_tests++; if (wb_ready !== m_ready()) begin n_fail++; $display("FAIL rand_ready_cyc%0d got %b exp %b", c, wb_ready, m_ready()); end
      n_tests++; if (bank_we !== m_we) begin n_fail++; $display("FAIL rand_we_cyc%0d got %b exp %b", c, bank_we, m_we); end
      n_tests++; if (idle !== m_idle()) begin n_fail++; $display("FAIL rand_idle_cyc%0d got %b exp %b", c, idle, m_idle()); end
      for (int b = 0; b < 4; b++) begin
        n_tests++;
        if (bank_waddr[b*YW +: YW] !== m_waddr[b] || bank_wdata[b*DW +: DW] !== m_wdata[b]) begin
          n_fail++;
          $display("FAIL rand_bank%0d_cyc%0d addr %0d data %h exp %0d %h", b, c, bank_waddr[b*YW +: YW], bank_wdata[b*DW +: DW], m_waddr[b], m_wdata[b]);
        end
      end
    end
    for (int p = 0; p < P; p++) drive(p, 1'b0, '0, '0);
    for (int c = 0; c < 12; c++) cycle();
    n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rand_drain_idle got %b exp 1", idle); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_parallel_banks();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
